// File: rtl/lock_qualifier.sv
// lock_qualifier: debounces the asynchronous MMCM locked flag and releases a qualified
// active-low reset (resetn_out) only after lock has been continuously stable. Any loss of
// lock forces a minimum hold-off followed by full requalification. The MMCM itself is held
// in reset (mmcm_reset) after board reset and, when LOCK_QUALIFIER_RETRY_EN is defined,
// again whenever lock is not achieved within TIMEOUT_CYCLES.
// Optional feature macro: LOCK_QUALIFIER_RETRY_EN (undefined by default: no timeout/retry).
module lock_qualifier #(
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 1048576,
  parameter int unsigned MMCM_RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       resetn_async,
  input  logic       locked,
  output logic       mmcm_reset,
  output logic       resetn_out,
  output logic [7:0] loss_count,
  output logic [7:0] retry_count
);

  // Counter widths; clamped to 1 bit so a parameter of 1 still gives a legal vector.
  localparam int unsigned STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned MRST_W   = (MMCM_RST_CYCLES > 1) ? $clog2(MMCM_RST_CYCLES) : 1;

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [MRST_W-1:0]   MRST_LAST   = MRST_W'(MMCM_RST_CYCLES - 1);

  localparam logic [2:0] ST_MRST = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_QUAL = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  logic                sync1_q;
  logic                locked_s;
  logic [2:0]          state_q, state_d;
  logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [MRST_W-1:0]   mrst_cnt_q, mrst_cnt_d;
  logic [7:0]          loss_q, loss_d;

`ifdef LOCK_QUALIFIER_RETRY_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       retry_q, retry_d;
`endif

  // Two-flop synchronizer for the asynchronous locked flag.
  always_ff @(posedge clk or negedge resetn_async) begin
    if (!resetn_async) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= locked;
      locked_s <= sync1_q;
    end
  end

  // Next-state and counter logic for the qualification FSM.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    mrst_cnt_d   = mrst_cnt_q;
    loss_d       = loss_q;

    case (state_q)
      ST_MRST: begin
        if (mrst_cnt_q == MRST_LAST) begin
          state_d    = ST_WAIT;
          mrst_cnt_d = '0;
        end else begin
          mrst_cnt_d = mrst_cnt_q + MRST_W'(1);
        end
      end
      ST_WAIT: begin
        if (locked_s) begin
          state_d      = ST_QUAL;
          stable_cnt_d = '0;
        end
      end
      ST_QUAL: begin
        if (!locked_s) begin
          state_d      = ST_WAIT;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_LAST) begin
          state_d      = ST_RUN;
          stable_cnt_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + STABLE_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
        end
      end
      ST_HOLD: begin
        // Lock status is deliberately ignored until the hold-off has elapsed.
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_WAIT;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_MRST;
      end
    endcase

`ifdef LOCK_QUALIFIER_RETRY_EN
    tmo_cnt_d = tmo_cnt_q;
    retry_d   = retry_q;
    if ((state_q == ST_WAIT) || (state_q == ST_QUAL)) begin
      // QUAL completion beats an expiring timeout; QUAL->WAIT flapping keeps counting.
      if (state_d == ST_RUN) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_LAST) begin
        state_d      = ST_MRST;
        mrst_cnt_d   = '0;
        stable_cnt_d = '0;
        tmo_cnt_d    = '0;
        if (retry_q != 8'hff) retry_d = retry_q + 8'd1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
`endif
  end

  // State and counter registers; board reset returns everything to MRST at once.
  always_ff @(posedge clk or negedge resetn_async) begin
    if (!resetn_async) begin
      state_q      <= ST_MRST;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      mrst_cnt_q   <= '0;
      loss_q       <= '0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      mrst_cnt_q   <= mrst_cnt_d;
      loss_q       <= loss_d;
    end
  end

`ifdef LOCK_QUALIFIER_RETRY_EN
  // Timeout counter and retry statistics.
  always_ff @(posedge clk or negedge resetn_async) begin
    if (!resetn_async) begin
      tmo_cnt_q <= '0;
      retry_q   <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      retry_q   <= retry_d;
    end
  end

  assign retry_count = retry_q;
`else
  assign retry_count = 8'd0;
`endif

  // Outputs decode the registered state only, so they follow reset asynchronously.
  assign mmcm_reset = (state_q == ST_MRST);
  assign resetn_out = (state_q == ST_RUN);
  assign loss_count = loss_q;

endmodule

// File: tb/tb_lock_qualifier.sv
// Bench for lock_qualifier. Each scenario is a per-edge waveform of the locked input; a
// reference model scans that waveform for qualifying lock runs, losses and timeouts and
// queues the expected output transitions (cycle stamp plus counter values). A separate
// monitor pops one entry for every transition it observes on resetn_out / mmcm_reset.
module tb_lock_qualifier;

  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int TMO    = 32;
  localparam int MR     = 4;
  localparam int MAXN   = 8192;

`ifdef LOCK_QUALIFIER_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam int K_RN_RISE = 0;
  localparam int K_RN_FALL = 1;
  localparam int K_MR_RISE = 2;
  localparam int K_MR_FALL = 3;

  logic       clk = 1'b0;
  logic       resetn_async = 1'b1;
  logic       locked = 1'b0;
  logic       mmcm_reset;
  logic       resetn_out;
  logic [7:0] loss_count;
  logic [7:0] retry_count;

  lock_qualifier #(
    .STABLE_CYCLES  (STABLE),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .MMCM_RST_CYCLES(MR)
  ) dut (
    .clk         (clk),
    .resetn_async(resetn_async),
    .locked      (locked),
    .mmcm_reset  (mmcm_reset),
    .resetn_out  (resetn_out),
    .loss_count  (loss_count),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
    int loss;
    int retry;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  lvl[MAXN];
  int  m_loss, m_retry;
  bit  m_rn, m_mr;
  bit  mon_en = 1'b0;
  logic prev_rn, prev_mr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchronized lock as seen by the FSM at edge n (sync flops reset to 0).
  function automatic bit s_at(input int n);
    return (n >= 3) ? lvl[n-2] : 1'b0;
  endfunction

  // First edge r in [w, lim] ending a run of STABLE+1 consecutive synchronized-lock cycles
  // that starts no earlier than w; -1 if none.
  function automatic int find_run(input int w, input int lim);
    int c = 0;
    for (int n = w; n <= lim; n++) begin
      if (s_at(n)) begin
        c++;
        if (c == STABLE + 1) return n;
      end else begin
        c = 0;
      end
    end
    return -1;
  endfunction

  task automatic push(input int kind, input int at, input int loss, input int retry);
    ev_t e;
    e.kind  = kind;
    e.at    = at;
    e.loss  = loss;
    e.retry = retry;
    exp_q.push_back(e);
  endtask

  // Expected transitions for edges 1..n_last after reset release (edge 0 = base).
  task automatic model(input int base, input int n_last);
    int ph, m, w, r, f, lim;
    m_loss = 0; m_retry = 0; m_rn = 1'b0; m_mr = 1'b1;
    m = 0; w = 0; r = 0; ph = 0;
    while (ph >= 0) begin
      if (ph == 0) begin
        // MMCM reset phase that began at edge m
        if (m + MR > n_last) ph = -1;
        else begin
          push(K_MR_FALL, base + m + MR, m_loss, m_retry);
          m_mr = 1'b0;
          w = m + MR + 1;
          ph = 1;
        end
      end else if (ph == 1) begin
        // waiting for lock from edge w, timeout clock starting at zero
        lim = RETRY ? (w + TMO - 1) : n_last;
        r = find_run(w, (lim < n_last) ? lim : n_last);
        if (r >= 0) begin
          push(K_RN_RISE, base + r, m_loss, m_retry);
          m_rn = 1'b1;
          ph = 2;
        end else if (RETRY && lim <= n_last) begin
          m = lim;
          if (m_retry < 255) m_retry++;
          push(K_MR_RISE, base + m, m_loss, m_retry);
          m_mr = 1'b1;
          ph = 0;
        end else begin
          ph = -1;
        end
      end else begin
        // running: first edge that sees lock dropped
        f = -1;
        for (int n = r + 1; n <= n_last && f < 0; n++) if (!s_at(n)) f = n;
        if (f < 0) ph = -1;
        else begin
          if (m_loss < 255) m_loss++;
          push(K_RN_FALL, base + f, m_loss, m_retry);
          m_rn = 1'b0;
          w = f + HOLD + 1;
          ph = 1;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  task automatic take(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d, required no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || e.loss !== int'(loss_count) ||
          e.retry !== int'(retry_count)) begin
        failures++;
        $display("FAIL event: got kind=%0d cyc=%0d loss=%0d retry=%0d, required kind=%0d cyc=%0d loss=%0d retry=%0d",
                 kind, cyc, loss_count, retry_count, e.kind, e.at, e.loss, e.retry);
      end
    end
  endtask

  always begin
    @(clk or negedge resetn_async);
    #1;
    if (mon_en) begin
      if (resetn_out !== prev_rn) begin
        take(resetn_out ? K_RN_RISE : K_RN_FALL);
        prev_rn = resetn_out;
      end
      if (mmcm_reset !== prev_mr) begin
        take(mmcm_reset ? K_MR_RISE : K_MR_FALL);
        prev_mr = mmcm_reset;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill(input int from, input int to, input bit v);
    for (int n = from; n <= to; n++) lvl[n] = v;
  endtask

  task automatic gen_random(input int n_last);
    int  n = 1;
    int  len;
    bit  v = 1'b0;
    while (n <= n_last) begin
      len = v ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
      for (int k = 0; k < len && n <= n_last; k++) begin
        lvl[n] = v;
        n++;
      end
      v = ~v;
    end
  endtask

  // Release reset, play lvl[1..n_last], then assert reset one edge later mid-cycle.
  task automatic run_scenario(input string name, input int n_last);
    int base;
    @(negedge clk);
    base = cyc;
    model(base, n_last);
    resetn_async = 1'b1;
    locked = lvl[1];
    for (int n = 2; n <= n_last; n++) begin
      @(negedge clk);
      locked = lvl[n];
    end
    @(posedge clk);
    #1;
    chk({name, "_loss_count"}, loss_count, m_loss);
    chk({name, "_retry_count"}, retry_count, m_retry);
    // Reset is asserted between edges: outputs must respond with no clock edge.
    if (m_rn) push(K_RN_FALL, base + n_last, 0, 0);
    if (!m_mr) push(K_MR_RISE, base + n_last, 0, 0);
    #1;
    resetn_async = 1'b0;
    locked = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk({name, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
    chk({name, "_loss_after_reset"}, loss_count, 0);
  endtask

  int a, d;

  initial begin
    #1 resetn_async = 1'b0;
    #3;
    chk("reset_mmcm_reset", mmcm_reset, 1);
    chk("reset_resetn_out", resetn_out, 0);
    chk("reset_loss_count", loss_count, 0);
    chk("reset_retry_count", retry_count, 0);
    prev_rn = 1'b0;
    prev_mr = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(negedge clk);

    // Lock from edge 10, held; ends with async reset in RUN.
    fill(0, MAXN - 1, 1'b0);
    fill(10, 40, 1'b1);
    run_scenario("basic", 40);

    // One-cycle glitch early in qualification.
    a = 6 + int'($urandom_range(0, 6));
    fill(0, MAXN - 1, 1'b0);
    fill(a, 70, 1'b1);
    lvl[a + 4] = 1'b0;
    run_scenario("glitch", 70);

    // One-cycle drop while running.
    a = 6 + int'($urandom_range(0, 6));
    d = a + 10 + int'($urandom_range(1, 10));
    fill(0, MAXN - 1, 1'b0);
    fill(a, d + 40, 1'b1);
    lvl[d] = 1'b0;
    run_scenario("loss", d + 40);

    // Never locks: retries only with the feature enabled.
    fill(0, MAXN - 1, 1'b0);
    run_scenario("no_lock", 130);

    // Random lock waveforms.
    for (int i = 0; i < 6; i++) begin
      fill(0, MAXN - 1, 1'b0);
      gen_random(300);
      run_scenario("random", 300);
    end

    // Repeated losses until loss_count saturates.
    fill(0, MAXN - 1, 1'b0);
    for (int k = 0; k < 305; k++) begin
      fill(6 + 17 * k, 6 + 17 * k + 15, 1'b1);
    end
    run_scenario("saturate", 6 + 17 * 305);
    chk("saturate_model_loss", m_loss, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lock_qualifier.md
# lock_qualifier

- Sits directly upstream of the encoder's reset synchronizer. Runs on the free-running reference clock and owns the MMCM reset.
- Debounces the asynchronous MMCM `locked` flag. Releases a qualified active-low reset (`resetn_out`) only after lock has been continuously stable. Forces a minimum hold-off after any loss of lock.
- Optionally re-resets the MMCM when lock is not achieved in time.
- `resetn_out` drives the encoder's asynchronous reset input.

## Interface

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release; ≥2
- HOLD_CYCLES, 64: minimum cycles `resetn_out` stays low after a lock loss; ≥1
- TIMEOUT_CYCLES, 1048576: cycles allowed in WAIT+QUAL before an MMCM retry; ≥2
- MMCM_RST_CYCLES, 16: width of each `mmcm_reset` pulse; ≥1

Ports:
- clk  input  1  free-running reference clock (MMCM input clock)
- resetn_async  input  1  board reset; asynchronous assertion, active-low
- locked  input  1  MMCM locked flag, asynchronous to clk
- mmcm_reset  output  1  active-high reset to MMCM
- resetn_out  output  1  qualified lock, active-low; high only in RUN
- loss_count  output  8  saturating count of RUN→HOLD transitions
- retry_count  output  8  saturating count of timeout-triggered MRST entries

## Operation

- `locked` passes through a 2-flop synchronizer (reset to 0) → `locked_s`.
- State register, all async-cleared by `resetn_async`. Reset state MRST. Reset values: mmcm_reset=1, resetn_out=0, loss_count=0, retry_count=0, counters=0.
- Outputs are decoded from registered state: `mmcm_reset` = (state==MRST), `resetn_out` = (state==RUN).
- MRST: count MMCM_RST_CYCLES edges, then go to WAIT. Clear the timeout counter.
- WAIT: `locked_s`=1 → QUAL with stable counter=0.
- QUAL:
  - `locked_s`=0 → WAIT.
  - Otherwise the stable counter increments. When it equals STABLE_CYCLES-1 with `locked_s`=1 → RUN.
- RUN: `locked_s`=0 → HOLD; loss_count +1 (saturates at 255).
- HOLD:
  - Count HOLD_CYCLES edges, ignoring `locked_s`, then go to WAIT.
  - Lock regained during HOLD is still requalified in full.
- Timeout counter:
  - Runs in WAIT and QUAL. It is not cleared by QUAL→WAIT flapping.
  - Cleared on entry to RUN and in MRST/HOLD.
- Counter widths are `$clog2` of their respective parameter; there is no wrap inside any state.
- Reset mid-operation: any state returns to MRST immediately, and outputs assume their reset values asynchronously.

## Timing

- Let e0 be the first clk edge at which sync flop 1 captures `locked`=1 while in WAIT, with lock held:
  - `locked_s`=1 after e0+1.
  - QUAL entered at e0+2.
  - `resetn_out` rises after edge e0+STABLE_CYCLES+2.
- Loss in RUN: first capture at e0 → HOLD at e0+2, so `resetn_out` falls after e0+2. Earliest return to WAIT is HOLD_CYCLES edges later.
- `mmcm_reset` stays high for exactly MMCM_RST_CYCLES edges per MRST visit, including after deassertion of `resetn_async`.
- Simultaneous events: timeout expiry in the same cycle as QUAL completion → RUN wins and no retry is counted.

## Configuration

- LOCK_QUALIFIER_RETRY_EN defined: when the timeout counter reaches TIMEOUT_CYCLES-1 in WAIT/QUAL, the next state is MRST and retry_count increments (saturating).
- LOCK_QUALIFIER_RETRY_EN undefined:
  - No timeout logic; WAIT/QUAL wait indefinitely.
  - MRST is visited only after `resetn_async`.
  - retry_count is tied to 0.

## Test plan

Benches use STABLE_CYCLES=8, HOLD_CYCLES=4, TIMEOUT_CYCLES=32, MMCM_RST_CYCLES=4.

- Reset release, then `locked` held high from edge 10:
  - `mmcm_reset` is high for 4 edges after reset release.
  - `resetn_out` rises after edge e0+10.
  - loss_count=0.
- Lock glitch: `locked` low for 1 cycle at the 5th QUAL cycle → QUAL restarts; `resetn_out` rises 8 qualified cycles after the glitch clears.
- Loss in RUN: `locked` drops for 1 cycle → `resetn_out` low 2 edges later and stays low ≥4 edges plus requalification. loss_count=1.
- Retry (macro on): `locked` held low → `mmcm_reset` pulses 4 cycles after 32 WAIT cycles, repeating. retry_count=3 after 3 timeouts. With the macro off, `mmcm_reset` stays low.
- Async reset asserted mid-RUN:
  - `resetn_out`=0 and `mmcm_reset`=1 immediately, without a clock edge.
  - Counts cleared.
- Saturation: 300 lock losses → loss_count=255.
